// File: rtl/vector_mem_unit.sv
// Vector load/store memory stage: moves 16 half-precision lanes between a 256-bit vector and 16-bit memory.
// Build option VMEM_STRIDE_EN adds a stride input; element i then lives at base_addr + i*stride.
module vector_mem_unit #(
  parameter int LANES  = 16,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [ADDR_W-1:0]         base_addr,
`ifdef VMEM_STRIDE_EN
  input  logic [ADDR_W-1:0]         stride,
`endif
  input  logic [LANES*ELEM_W-1:0]   store_data,
  output logic                      busy,
  output logic                      done,
  output logic [LANES*ELEM_W-1:0]   load_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic [ELEM_W-1:0]         mem_wdata,
  input  logic [ELEM_W-1:0]         mem_rdata
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_LOAD_DRAIN = 3'd2;
  localparam logic [2:0] S_STORE      = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  logic [2:0]              state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_next;
  logic [IDX_W-1:0]        idx_prev;
  logic [LANES*ELEM_W-1:0] store_q;
  logic [ADDR_W-1:0]       step;

  assign idx_next = idx + IDX_W'(1);
  assign idx_prev = idx - IDX_W'(1);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Addresses advance incrementally by the step, so no multiplier is needed for strided access.
`ifdef VMEM_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else if (state == S_IDLE && start) begin
      stride_q <= stride;
    end
  end

  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  // mem_addr always holds the address of element idx; read data lags one cycle, so a
  // load writes lane idx-1 while issuing idx, and the drain state collects the final lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      store_q   <= '0;
      load_data <= '0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx      <= '0;
            store_q  <= store_data;
            mem_addr <= base_addr;
            if (is_store) begin
              state     <= S_STORE;
              mem_we    <= 1'b1;
              mem_wdata <= store_data[ELEM_W-1:0];
            end else begin
              state  <= S_LOAD;
              mem_re <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (idx != '0) begin
            load_data[ELEM_W*idx_prev +: ELEM_W] <= mem_rdata;
          end
          if (idx == LAST_IDX) begin
            mem_re <= 1'b0;
            state  <= S_LOAD_DRAIN;
          end else begin
            idx      <= idx_next;
            mem_addr <= mem_addr + step;
          end
        end
        S_LOAD_DRAIN: begin
          load_data[ELEM_W*LAST_IDX +: ELEM_W] <= mem_rdata;
          state <= S_DONE;
        end
        S_STORE: begin
          if (idx == LAST_IDX) begin
            mem_we <= 1'b0;
            state  <= S_DONE;
          end else begin
            idx       <= idx_next;
            mem_addr  <= mem_addr + step;
            mem_wdata <= store_q[ELEM_W*idx_next +: ELEM_W];
          end
        end
        S_DONE: begin
          idx   <= '0;
          state <= S_IDLE;
        end
        default: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
